vco_freq_counter: RTL and testbench
===================================

// Module: vco_freq_counter
// PURPOSE
//   Digital readout stage downstream of the dual ring-VCO macro. Samples both free-running
//   oscillator outputs (vco_a, vco_b; asynchronous to clk) and counts their rising edges over a
//   fixed gate window of GATE_CYCLES clk periods. Latches both counts plus overflow flags and
//   exposes them as parallel words and as a byte-muxed bus for the uo_out pins.
// PARAMETERS
//   GATE_CYCLES  1000  gate window length in clk cycles (>=2)
//   CNT_W        16    edge-counter width per channel (1..16)
//   SYNC_STAGES  2     synchroniser flops per VCO input (>=2)
// PORTS
//   clk       in   1      system clock
//   rst       in   1      synchronous reset, active-high
//   ena       in   1      design enable; low aborts/holds the FSM in IDLE
//   start     in   1      single-measurement request, level-sampled in IDLE
//   cont      in   1      1 = re-arm automatically after each LATCH
//   vco_a     in   1      oscillator A output, asynchronous
//   vco_b     in   1      oscillator B output, asynchronous
//   byte_sel  in   3      readout byte select
//   busy      out  1      high in ARM, GATE and LATCH
//   valid     out  1      one-cycle pulse when new results are latched
//   cnt_a     out  CNT_W  latched edge count, channel A
//   cnt_b     out  CNT_W  latched edge count, channel B
//   ovf_a     out  1      channel A saturated during the last window
//   ovf_b     out  1      channel B saturated during the last window
//   data_out  out  8      byte-muxed readout
// BEHAVIOUR
//   Reset: FSM=IDLE; busy, valid, cnt_a, cnt_b, ovf_a, ovf_b = 0; sync chains and live counters 0.
//   FSM: IDLE -> ARM when (ena & (start|cont)); ARM -> GATE (live counters, ovf, gate timer cleared);
//     GATE lasts exactly GATE_CYCLES cycles, then -> LATCH; LATCH: result regs <= live regs,
//     valid=1 for this cycle only; LATCH -> ARM if (ena & cont), else -> IDLE.
//   Latency: start high at edge t -> ARM t+1, GATE t+2..t+1+GATE_CYCLES, valid at t+2+GATE_CYCLES.
//   Edge detect: SYNC_STAGES-flop sync, then rise = sync_q & ~prev_q. A rise counts only in a
//     GATE cycle, including the first and last GATE cycles. Rises in ARM/LATCH/IDLE are dropped.
//   Saturation: counter stops at 2^CNT_W-1; a further rise sets live ovf (sticky to window end).
//   Aliasing: VCO frequency must be < clk/2; higher frequencies under-count with no error flag.
//   start while busy: ignored. Dropping cont mid-window: current window still completes.
//   ena low: in ARM/GATE abort to IDLE next cycle, results untouched, no valid; in LATCH the latch
//     still completes (valid pulses), then -> IDLE.
//   rst mid-window: everything returns to reset values next cycle; no valid pulse.
//   Results hold their value between windows; they are updated only in LATCH.
//   data_out (combinational from registered results, zero-extended to 16 bits):
//     0: cnt_a[7:0]  1: cnt_a[15:8]  2: cnt_b[7:0]  3: cnt_b[15:8]
//     4: {5'b0, busy, ovf_b, ovf_a}  5..7: 8'h00
// STRUCTURE
//   Package vco_meas_pkg: FSM state enum (IDLE, ARM, GATE, LATCH); byte_sel encodings
//     (SEL_A_LO..SEL_STATUS); STATUS bit positions.
//   Sub-module vco_edge_counter (sync chain + rise detect + saturating counter + sticky ovf,
//     inputs clr/en); instantiated twice, for A and B.
//   Top: FSM, gate timer ($clog2(GATE_CYCLES) bits), result registers, readout mux.
// TESTING
//   1) GATE_CYCLES=1000, vco_a period 10 clk, vco_b period 4 clk, start pulse -> valid at t+1002,
//      cnt_a=100, cnt_b=250, ovf=0; byte_sel=2,3 -> 8'hFA, 8'h00.
//   2) CNT_W=8, vco_a period 2 clk, GATE_CYCLES=1000 -> cnt_a=255, ovf_a=1; status byte = 8'h01.
//   3) cont=1 with a fixed 7-clk VCO -> valid every GATE_CYCLES+2 cycles, identical counts each
//      window; cont dropped mid-window -> that window completes, FSM returns to IDLE.
//   4) rst asserted at GATE cycle 500 -> next cycle all outputs 0, busy=0, no valid pulse.
//   5) ena low at GATE cycle 300 -> IDLE, prior cnt_a/cnt_b unchanged, no valid pulse;
//      start held while busy -> no extra window.
//   6) Single rise placed exactly in the first and in the last GATE cycle -> each counted (cnt=1);
//      rise in the ARM cycle or the LATCH cycle -> not counted (cnt=0).

Source files
------------

// File: rtl/vco_meas_pkg.sv
// Shared types and constants for the dual-VCO frequency counter.
package vco_meas_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StGate,
    StLatch
  } meas_state_e;

  // Readout byte select encodings
  localparam logic [2:0] SEL_A_LO   = 3'd0;
  localparam logic [2:0] SEL_A_HI   = 3'd1;
  localparam logic [2:0] SEL_B_LO   = 3'd2;
  localparam logic [2:0] SEL_B_HI   = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;

  // Bit positions inside the status byte
  localparam int unsigned STATUS_OVF_A = 0;
  localparam int unsigned STATUS_OVF_B = 1;
  localparam int unsigned STATUS_BUSY  = 2;

endpackage

// File: rtl/vco_edge_counter.sv
// One VCO channel: synchroniser, rising-edge detect, saturating edge counter with sticky overflow.
module vco_edge_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vco_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             ovf_next_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  // Shift the asynchronous VCO level through the synchroniser and remember the last synced level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], vco_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Count rises while enabled; hold at all-ones and flag any rise beyond that
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i && rise) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next-state values let the top capture a rise from the final gate cycle
  assign cnt_next_o = cnt_d;
  assign ovf_next_o = ovf_d;

endmodule

// File: rtl/vco_freq_counter.sv
// Gated dual-channel VCO edge counter with latched results and a byte-muxed readout.
module vco_freq_counter
  import vco_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             cont,
  input  logic             vco_a,
  input  logic             vco_b,
  input  logic [2:0]       byte_sel,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             ovf_a,
  output logic             ovf_b,
  output logic [7:0]       data_out
);

  localparam int unsigned       TimerW    = $clog2(GATE_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(GATE_CYCLES - 1);

  meas_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic              ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic              load_res;
  logic              live_clr, live_en;
  logic [CNT_W-1:0]  live_cnt_a, live_cnt_b;
  logic              live_ovf_a, live_ovf_b;
  logic [15:0]       res_a_ext, res_b_ext;

  assign live_clr = (state_q == StArm);
  assign live_en  = (state_q == StGate);

  vco_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .vco_i      (vco_a),
    .clr_i      (live_clr),
    .en_i       (live_en),
    .cnt_next_o (live_cnt_a),
    .ovf_next_o (live_ovf_a)
  );

  vco_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .vco_i      (vco_b),
    .clr_i      (live_clr),
    .en_i       (live_en),
    .cnt_next_o (live_cnt_b),
    .ovf_next_o (live_ovf_b)
  );

  // Sequencer: arm, gate for exactly GATE_CYCLES, latch; ena low aborts arm/gate
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    load_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ena && (start || cont)) state_d = StArm;
      end
      StArm: begin
        timer_d = '0;
        state_d = ena ? StGate : StIdle;
      end
      StGate: begin
        if (!ena) begin
          state_d = StIdle;
        end else if (timer_q == TimerLast) begin
          // Capture on entry to LATCH so results and valid appear together
          state_d  = StLatch;
          load_res = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StLatch: begin
        state_d = (ena && cont) ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Result registers only change when a window completes
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    ovf_a_d = ovf_a_q;
    ovf_b_d = ovf_b_q;
    if (load_res) begin
      cnt_a_d = live_cnt_a;
      cnt_b_d = live_cnt_b;
      ovf_a_d = live_ovf_a;
      ovf_b_d = live_ovf_b;
    end
  end

  // State, timer and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      ovf_a_q <= ovf_a_d;
      ovf_b_q <= ovf_b_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = (state_q == StLatch);
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
  assign ovf_a = ovf_a_q;
  assign ovf_b = ovf_b_q;

  assign res_a_ext = 16'(cnt_a_q);
  assign res_b_ext = 16'(cnt_b_q);

  // Byte-wide readout of the latched results
  always_comb begin
    data_out = 8'h00;
    case (byte_sel)
      SEL_A_LO: data_out = res_a_ext[7:0];
      SEL_A_HI: data_out = res_a_ext[15:8];
      SEL_B_LO: data_out = res_b_ext[7:0];
      SEL_B_HI: data_out = res_b_ext[15:8];
      SEL_STATUS: begin
        data_out[STATUS_OVF_A] = ovf_a_q;
        data_out[STATUS_OVF_B] = ovf_b_q;
        data_out[STATUS_BUSY]  = busy;
      end
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vco_freq_counter.sv
// Directed bench for vco_freq_counter; a second instance with CNT_W=8 covers saturation.
module tb_vco_freq_counter;

  localparam int unsigned G     = 1000;
  localparam int          Never = 1 << 30;

  logic        clk = 1'b0;
  logic        rst, ena, start, cont, vco_a, vco_b;
  logic [2:0]  byte_sel;
  logic        busy, valid, ovf_a, ovf_b;
  logic [15:0] cnt_a, cnt_b;
  logic [7:0]  data_out;
  logic        busy8, valid8, ovf_a8, ovf_b8;
  logic [7:0]  cnt_a8, cnt_b8;
  logic [7:0]  data_out8;

  int n_pass  = 0;
  int n_total = 0;
  // Negedge index relative to the negedge where start is driven (k = 0)
  int kk = 0;
  // VCO stimulus: period in clk cycles (0 = manual step at rise_*), phase shift
  int per_a = 0, per_b = 0, sh_a = 0, sh_b = 0, rise_a = Never, rise_b = Never;
  int seen;

  always #5 clk = ~clk;

  vco_freq_counter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .cont(cont), .vco_a(vco_a), .vco_b(vco_b),
    .byte_sel(byte_sel), .busy(busy), .valid(valid), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .ovf_a(ovf_a), .ovf_b(ovf_b), .data_out(data_out)
  );

  vco_freq_counter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .cont(cont), .vco_a(vco_a), .vco_b(vco_b),
    .byte_sel(byte_sel), .busy(busy8), .valid(valid8), .cnt_a(cnt_a8), .cnt_b(cnt_b8),
    .ovf_a(ovf_a8), .ovf_b(ovf_b8), .data_out(data_out8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Square wave with rises where (k + s) is a multiple of p, or a single step at r when p == 0
  function automatic logic vco_val(input int k, input int p, input int s, input int r);
    if (p == 0) return (k >= r);
    return (((k + s + 4 * p) % p) < (p / 2));
  endfunction

  task automatic tick();
    @(negedge clk);
    kk++;
    vco_a = vco_val(kk, per_a, sh_a, rise_a);
    vco_b = vco_val(kk, per_b, sh_b, rise_b);
  endtask

  // Drive start (and cont) at k = 0; returns at k = 1
  task automatic start_window(input logic hold, input logic c);
    kk = -3;
    tick(); tick(); tick();
    start = 1'b1;
    cont  = c;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_valid(input int exp_k, input string tag);
    while (!valid && kk < exp_k + 20) tick();
    check_eq(tag, kk, exp_k);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; cont = 1'b0; byte_sel = 3'd4;
    vco_a = 1'b0; vco_b = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_cnt_a", cnt_a, 16'd0);
    check_eq("rst_cnt_b", cnt_b, 16'd0);
    check_eq("rst_ovf", {ovf_b, ovf_a}, 2'b00);
    check_eq("rst_status", data_out, 8'h00);
    rst = 1'b0;
    repeat (3) tick();

    // 1) A period 10, B period 4
    per_a = 10; per_b = 4;
    repeat (5) tick();
    start_window(1'b0, 1'b0);
    check_eq("t1_busy_arm", busy, 1'b1);
    wait_valid(G + 2, "t1_latency");
    check_eq("t1_cnt_a", cnt_a, 16'd100);
    check_eq("t1_cnt_b", cnt_b, 16'd250);
    check_eq("t1_ovf", {ovf_b, ovf_a}, 2'b00);
    byte_sel = 3'd0; #1 check_eq("t1_byte0", data_out, 8'h64);
    byte_sel = 3'd2; #1 check_eq("t1_byte2", data_out, 8'hFA);
    byte_sel = 3'd3; #1 check_eq("t1_byte3", data_out, 8'h00);
    byte_sel = 3'd6; #1 check_eq("t1_byte6", data_out, 8'h00);
    tick();
    check_eq("t1_valid_pulse", valid, 1'b0);
    check_eq("t1_idle", busy, 1'b0);

    // 2) A period 2 saturates the 8-bit instance
    per_a = 2; per_b = 10;
    repeat (5) tick();
    start_window(1'b0, 1'b0);
    wait_valid(G + 2, "t2_latency");
    check_eq("t2_cnt_a8", cnt_a8, 8'd255);
    check_eq("t2_ovf_a8", ovf_a8, 1'b1);
    check_eq("t2_cnt_b8", cnt_b8, 8'd100);
    check_eq("t2_ovf_b8", ovf_b8, 1'b0);
    check_eq("t2_cnt_a16", cnt_a, 16'd500);
    check_eq("t2_ovf_a16", ovf_a, 1'b0);
    tick();
    byte_sel = 3'd4; #1 check_eq("t2_status8", data_out8, 8'h01);

    // 3) Continuous mode, A period 7 (phase keeps 143 per window), B period 5
    per_a = 7; sh_a = 4; per_b = 5;
    repeat (5) tick();
    start_window(1'b0, 1'b1);
    wait_valid(G + 2, "t3_w1_latency");
    check_eq("t3_w1_cnt_a", cnt_a, 16'd143);
    check_eq("t3_w1_cnt_b", cnt_b, 16'd200);
    tick();
    wait_valid(2 * (G + 2), "t3_w2_latency");
    check_eq("t3_w2_cnt_a", cnt_a, 16'd143);
    check_eq("t3_w2_cnt_b", cnt_b, 16'd200);
    tick();
    while (kk < 2500) tick();
    cont = 1'b0;
    wait_valid(3 * (G + 2), "t3_w3_latency");
    check_eq("t3_w3_cnt_a", cnt_a, 16'd143);
    tick();
    seen = 0;
    repeat (20) begin
      tick();
      if (busy) seen++;
    end
    check_eq("t3_idle_after_drop", seen, 0);

    // 5) ena low in GATE with start held: abort, results kept, no valid
    per_a = 10; sh_a = 0; per_b = 4;
    start_window(1'b1, 1'b0);
    while (kk < 300) tick();
    ena = 1'b0; start = 1'b0;
    tick();
    check_eq("t5_abort_busy", busy, 1'b0);
    check_eq("t5_keep_cnt_a", cnt_a, 16'd143);
    check_eq("t5_keep_cnt_b", cnt_b, 16'd200);
    ena = 1'b1;
    seen = 0;
    repeat (G + 10) begin
      tick();
      if (valid || busy) seen++;
    end
    check_eq("t5_no_valid", seen, 0);
    // start held for the whole busy period must not queue a second window
    start_window(1'b1, 1'b0);
    while (kk < G) tick();
    start = 1'b0;
    wait_valid(G + 2, "t5b_latency");
    check_eq("t5b_cnt_a", cnt_a, 16'd100);
    tick();
    seen = 0;
    repeat (30) begin
      tick();
      if (busy) seen++;
    end
    check_eq("t5b_no_extra", seen, 0);

    // 4) rst in GATE cycle 500
    start_window(1'b0, 1'b0);
    while (kk < 500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t4_busy", busy, 1'b0);
    check_eq("t4_valid", valid, 1'b0);
    check_eq("t4_cnt_a", cnt_a, 16'd0);
    check_eq("t4_cnt_b", cnt_b, 16'd0);
    check_eq("t4_status", data_out, 8'h00);
    seen = 0;
    repeat (G + 10) begin
      tick();
      if (valid) seen++;
    end
    check_eq("t4_no_valid", seen, 0);

    // 6) Single rises at the window boundaries
    per_a = 0; per_b = 0;
    repeat (5) tick();
    rise_a = 0; rise_b = -1;
    start_window(1'b0, 1'b0);
    wait_valid(G + 2, "t6a_latency");
    check_eq("t6_first_gate", cnt_a, 16'd1);
    check_eq("t6_arm_drop", cnt_b, 16'd0);
    rise_a = Never; rise_b = Never;
    repeat (5) tick();
    rise_a = G - 1; rise_b = G;
    start_window(1'b0, 1'b0);
    wait_valid(G + 2, "t6b_latency");
    check_eq("t6_last_gate", cnt_a, 16'd1);
    check_eq("t6_latch_drop", cnt_b, 16'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
